// File: rtl/reg_write_ctrl.sv
// rtl/reg_write_ctrl.sv - debounced push-button register-bank writer with clear-all sweep
// Optional address auto-increment pointer: define REG_WRITE_CTRL_AUTO_INC_EN.
module reg_write_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_write,
  input  logic       btn_clear,
  input  logic [2:0] sw_addr,
  input  logic [3:0] sw_data,
  output logic [2:0] addrW,
  output logic [3:0] datW,
  output logic       RegWrite,
  output logic       busy,
  output logic [7:0] wr_count
);

  // The counter doubles as the clear-sweep index, so it needs at least 3 bits.
  localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 3) ? $clog2(DEBOUNCE_CYCLES) : 3;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(7);

  typedef enum logic [2:0] {
    IDLE, DEB_PRESS, WRITE, CLEAR, WAIT_REL, DEB_REL
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      wsync_q, csync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      addr_q, addr_d;
  logic [3:0]      dat_q, dat_d;
  logic            we_q, we_d;
  logic [7:0]      wrc_q, wrc_d;
  logic            w_s, c_s;
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
  logic [2:0]      ptr_q, ptr_d;
`endif

  assign w_s = wsync_q[1];
  assign c_s = csync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wsync_q <= '0;
      csync_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      wrc_q   <= '0;
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wsync_q <= {wsync_q[0], btn_write};
      csync_q <= {csync_q[0], btn_clear};
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      wrc_q   <= wrc_d;
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (c_s) state_d = CLEAR;
                 else if (w_s) state_d = DEB_PRESS;
      DEB_PRESS: if (!w_s) state_d = IDLE;
                 else if (cnt_q == DEB_LAST) state_d = WRITE;
      WRITE:     state_d = WAIT_REL;
      CLEAR:     if (cnt_q == CLR_LAST) state_d = WAIT_REL;
      WAIT_REL:  if (!w_s && !c_s) state_d = DEB_REL;
      DEB_REL:   if (w_s || c_s) state_d = WAIT_REL;
                 else if (cnt_q == DEB_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Strobe and bank outputs are registered, so they are set on the edge entering WRITE/CLEAR.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    dat_d  = dat_q;
    we_d   = 1'b0;
    wrc_d  = wrc_q;
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
    ptr_d  = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (c_s) begin
          cnt_d  = '0;
          addr_d = 3'd0;
          dat_d  = 4'd0;
          we_d   = 1'b1;
          wrc_d  = 8'd0;
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
          ptr_d  = 3'd0;
`endif
        end else if (w_s) begin
          cnt_d = '0;
        end
      end
      DEB_PRESS: begin
        if (w_s) begin
          if (cnt_q == DEB_LAST) begin
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
            addr_d = ptr_q;
`else
            addr_d = sw_addr;
`endif
            dat_d  = sw_data;
            we_d   = 1'b1;
            wrc_d  = (wrc_q == 8'hFF) ? wrc_q : wrc_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
        ptr_d = ptr_q + 3'd1;
`endif
      end
      CLEAR: begin
        if (cnt_q != CLR_LAST) begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = cnt_q[2:0] + 3'd1;
          dat_d  = 4'd0;
          we_d   = 1'b1;
        end
      end
      WAIT_REL: if (!w_s && !c_s) cnt_d = '0;
      DEB_REL:  if (!w_s && !c_s && cnt_q != DEB_LAST) cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    addrW    = addr_q;
    datW     = dat_q;
    RegWrite = we_q;
    wr_count = wrc_q;
  end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb/tb_reg_write_ctrl.sv - scoreboard bench for reg_write_ctrl with DEBOUNCE_CYCLES = 4
module tb_reg_write_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_write = 1'b0;
  logic       btn_clear = 1'b0;
  logic [2:0] sw_addr = '0;
  logic [3:0] sw_data = '0;
  logic [2:0] addrW;
  logic [3:0] datW;
  logic       RegWrite;
  logic       busy;
  logic [7:0] wr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  int exp_count = 0;
  logic [2:0] ptr_m = '0;
  logic [6:0] exp_q[$];

  reg_write_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_write(btn_write), .btn_clear(btn_clear),
    .sw_addr(sw_addr), .sw_data(sw_data), .addrW(addrW), .datW(datW),
    .RegWrite(RegWrite), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && RegWrite) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check("sb_addr", int'(addrW), int'(e[6:4]));
        check("sb_data", int'(datW), int'(e[3:0]));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, int'(busy), 0);
  endtask

  task automatic push_write(input logic [2:0] a, input logic [3:0] d);
`ifdef REG_WRITE_CTRL_AUTO_INC_EN
    exp_q.push_back({ptr_m, d});
    ptr_m = ptr_m + 3'd1;
`else
    exp_q.push_back({a, d});
`endif
    if (exp_count < 255) exp_count++;
  endtask

  // Button is raised at a negedge, so the next posedge is edge 0.
  task automatic measure_latency(input string tag);
    int e;
    e = 99;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (RegWrite) begin e = i; break; end
    end
    check(tag, e, 6);
  endtask

  task automatic press(input logic [2:0] a, input logic [3:0] d, input bit chk_lat);
    int p0;
    @(negedge clk);
    p0 = n_pulses;
    sw_addr = a;
    sw_data = d;
    push_write(a, d);
    btn_write = 1'b1;
    if (chk_lat) measure_latency("write_latency");
    cycles(12);
    btn_write = 1'b0;
    wait_idle("write_release");
    check("one_pulse_per_press", n_pulses - p0, 1);
    check("wr_count", int'(wr_count), exp_count);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 4'd0});
    exp_count = 0;
    ptr_m = '0;
  endtask

  initial begin
    int p0, k;
    cycles(2);
    check("rst_busy", int'(busy), 0);
    check("rst_regwrite", int'(RegWrite), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_addrW", int'(addrW), 0);
    check("rst_datW", int'(datW), 0);
    check("rst_wr_count", int'(wr_count), 0);

    press(3'd5, 4'hA, 1'b1);
`ifndef REG_WRITE_CTRL_AUTO_INC_EN
    check("clean_addrW", int'(addrW), 5);
    check("clean_datW", int'(datW), 10);
`endif

    // Bounce: high 2, low 1, then held; latency counted from the final rise.
    @(negedge clk);
    p0 = n_pulses;
    sw_addr = 3'd2; sw_data = 4'h3;
    push_write(3'd2, 4'h3);
    btn_write = 1'b1; cycles(2);
    btn_write = 1'b0; cycles(1);
    btn_write = 1'b1;
    measure_latency("bounce_latency");
    cycles(10);
    btn_write = 1'b0;
    wait_idle("bounce_release");
    check("bounce_one_pulse", n_pulses - p0, 1);

    press(3'd7, 4'h6, 1'b0);
    check("pre_clear_count", int'(wr_count), 3);

    // Clear sweep
    @(negedge clk);
    p0 = n_pulses;
    push_clear();
    btn_clear = 1'b1;
    k = 0;
    while (!RegWrite && k < 20) begin @(posedge clk); #1; k++; end
    for (int i = 0; i < 8; i++) begin
      check("clear_strobe", int'(RegWrite), 1);
      check("clear_addr", int'(addrW), i);
      @(posedge clk); #1;
    end
    check("clear_end_strobe", int'(RegWrite), 0);
    check("clear_wr_count", int'(wr_count), 0);
    cycles(10);
    check("clear_busy_held", int'(busy), 1);
    btn_clear = 1'b0;
    cycles(3);
    check("clear_busy_debouncing", int'(busy), 1);
    wait_idle("clear_release");
    check("clear_pulses", n_pulses - p0, 8);

    // Simultaneous buttons
    press(3'd1, 4'h9, 1'b0);
    @(negedge clk);
    p0 = n_pulses;
    push_clear();
    sw_addr = 3'd4; sw_data = 4'hF;
    btn_write = 1'b1; btn_clear = 1'b1;
    cycles(20);
    btn_write = 1'b0; btn_clear = 1'b0;
    wait_idle("simul_release");
    check("simul_pulses", n_pulses - p0, 8);
    check("simul_wr_count", int'(wr_count), 0);

    // Reset during the 3rd clear cycle
    @(negedge clk);
    p0 = n_pulses;
    exp_q.push_back({3'd0, 4'd0});
    exp_q.push_back({3'd1, 4'd0});
    btn_clear = 1'b1;
    k = 0;
    while (!(RegWrite && addrW == 3'd2) && k < 30) begin @(posedge clk); #1; k++; end
    check("reached_clear3", int'(addrW), 2);
    rst = 1'b1;
    #1;
    check("rst_mid_regwrite", int'(RegWrite), 0);
    check("rst_mid_busy", int'(busy), 0);
    btn_clear = 1'b0;
    ptr_m = '0;
    exp_count = 0;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    check("rst_mid_pulses", n_pulses - p0, 2);
    check("rst_mid_idle", int'(busy), 0);
    check("rst_mid_addrW", int'(addrW), 0);

`ifdef REG_WRITE_CTRL_AUTO_INC_EN
    for (int i = 0; i < 9; i++) begin
      press(3'($urandom_range(0, 7)), 4'(i), 1'b0);
      check("autoinc_addr", int'(addrW), i % 8);
    end
`else
    for (int i = 0; i < 3; i++) begin
      logic [2:0] a;
      logic [3:0] d;
      a = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      press(a, d, 1'b0);
      check("rand_addr", int'(addrW), int'(a));
    end
`endif

    cycles(4);
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a button edge (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_write  input  1  raw, bouncy write push button.
REQ-005 SHALL have port btn_clear  input  1  raw clear-all push button.
REQ-006 SHALL have port sw_addr  input  3  write address switches.
REQ-007 SHALL have port sw_data  input  4  write data switches.
REQ-008 SHALL have port addrW  output  3  register-bank write address, registered.
REQ-009 SHALL have port datW  output  4  register-bank write data, registered.
REQ-010 SHALL have port RegWrite  output  1  register-bank write strobe, registered, one cycle per write.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port wr_count  output  8  count of accepted single writes.

Function
REQ-013 SHALL pass btn_write and btn_clear through 2-flop synchronizers; the FSM uses only the synchronized values.
REQ-014 SHALL implement FSM states IDLE, DEB_PRESS, WRITE, CLEAR, WAIT_REL, DEB_REL.
REQ-015 IDLE: synchronized clear high -> CLEAR (clear takes priority over write); else synchronized write high -> DEB_PRESS with debounce counter = 0.
REQ-016 DEB_PRESS: synchronized write low -> IDLE; counter == DEBOUNCE_CYCLES-1 -> WRITE, latching sw_addr into addrW and sw_data into datW on that edge; otherwise counter +1.
REQ-017 WRITE: RegWrite = 1 for exactly this one cycle; wr_count +1, saturating at 255; next state WAIT_REL.
REQ-018 Latency: with btn_write held high, RegWrite rises on edge DEBOUNCE_CYCLES+2, where edge 0 is the first edge that samples btn_write = 1.
REQ-019 CLEAR: 8 consecutive cycles with RegWrite = 1, datW = 0, addrW = 0,1,...,7; wr_count set to 0; then WAIT_REL; clear is not debounced because it is idempotent.
REQ-020 WAIT_REL: when both synchronized buttons are low -> DEB_REL with counter = 0.
REQ-021 DEB_REL: either synchronized button high -> WAIT_REL; counter == DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-022 RegWrite SHALL be 0 in every state except WRITE and CLEAR; addrW and datW hold their last values outside those states.
REQ-023 Holding a button indefinitely SHALL produce exactly one write (or one clear sweep).
REQ-024 busy SHALL be combinational from the state register, with no additional latency.

Reset
REQ-025 On rst high, asynchronously: state = IDLE, synchronizers = 0, counter = 0, addrW = 0, datW = 0, RegWrite = 0, wr_count = 0, busy = 0.
REQ-026 Reset asserted mid-write or mid-clear SHALL abort immediately; no RegWrite pulse is emitted after rst rises, and an interrupted clear sweep is not resumed.

Configuration
REQ-027 Macro REG_WRITE_CTRL_AUTO_INC_EN SHALL control address auto-increment.
- Defined: a 3-bit pointer (reset 0) supplies addrW in WRITE, ignoring sw_addr. The pointer increments after each WRITE and wraps from 7 to 0. CLEAR resets the pointer to 0.
- Undefined: addrW comes from sw_addr as in REQ-016, and no pointer logic is compiled.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Clean press: btn_write held high, sw_addr = 5, sw_data = 0xA -> RegWrite high for exactly 1 cycle at edge 6 with addrW = 5, datW = 0xA; wr_count = 1.
REQ-029 Bounce: btn_write pulses high for 2 cycles, low for 1, then holds high -> exactly one RegWrite pulse, occurring 6 edges after the final rise.
REQ-030 Clear: after writes leave wr_count = 3, press btn_clear -> RegWrite high for 8 consecutive cycles with addrW = 0..7 and datW = 0; then wr_count = 0 and busy stays high until release is debounced.
REQ-031 Simultaneous buttons: btn_write and btn_clear rise on the same edge -> clear sweep only, with no single write.
REQ-032 Reset mid-clear: rst pulses during the 3rd clear cycle -> RegWrite = 0 and busy = 0 immediately, and state returns to IDLE.
REQ-033 With REG_WRITE_CTRL_AUTO_INC_EN defined, 9 clean presses -> addrW sequence 0,1,...,7,0 regardless of sw_addr.
